// File: rtl/ucode_useq.sv
// Microcode sequencer: owns the micro-PC, decodes the next-address format
// of the current microword and keeps a small LIFO of subroutine returns.
module ucode_useq #(
    parameter int RSTK_DEPTH = 2,
    parameter int AW         = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          u_start,
    input  logic [AW-1:0] u_entry_addr,
    input  logic          u_flush,
    input  logic          u_stall,
    input  logic [2:0]    u_nxt_fmt,
    input  logic [AW-1:0] u_target,
    input  logic [1:0]    br_sel,
    output logic [AW-1:0] u_addr,
    output logic          u_valid,
    output logic          u_busy,
    output logic          u_done,
    output logic          u_err,
    output logic [2:0]    u_rs_depth
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [2:0] F_CONT = 3'b000;
    localparam logic [2:0] F_JUMP = 3'b001;
    localparam logic [2:0] F_BR   = 3'b010;
    localparam logic [2:0] F_CALL = 3'b011;
    localparam logic [2:0] F_RET  = 3'b100;
    localparam logic [2:0] F_END  = 3'b101;

    localparam logic [2:0] RS_FULL = 3'(RSTK_DEPTH);

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] upc, upc_nxt;
    logic          valid_nxt, done_nxt, err_nxt;
    logic [2:0]    depth, depth_nxt;
    logic          push;
    logic [AW-1:0] upc_inc, tgt_inc;
    logic [1:0]    push_idx, top_idx;
    // Sized for the largest legal depth so any index from depth[1:0] is in range.
    logic [AW-1:0] rstk [0:3];

    assign upc_inc  = upc + AW'(1);
    assign tgt_inc  = u_target + AW'(1);
    assign push_idx = depth[1:0];
    assign top_idx  = depth[1:0] - 2'd1;

    always_comb begin
        state_nxt = state;
        upc_nxt   = upc;
        valid_nxt = u_valid;
        done_nxt  = 1'b0;
        err_nxt   = u_err;
        depth_nxt = depth;
        push      = 1'b0;
        if (u_flush) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
            depth_nxt = 3'd0;
        end else if (!u_stall) begin
            case (state)
                S_IDLE: begin
                    if (u_start) begin
                        upc_nxt   = u_entry_addr;
                        state_nxt = S_RUN;
                        valid_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    case (u_nxt_fmt)
                        F_CONT: upc_nxt = upc_inc;
                        F_JUMP: upc_nxt = u_target;
                        F_BR: begin
                            case (br_sel)
                                2'b10:   upc_nxt = u_target;
                                2'b11:   upc_nxt = tgt_inc;
                                default: upc_nxt = upc_inc;
                            endcase
                        end
                        F_CALL: begin
                            if (depth == RS_FULL) begin
                                state_nxt = S_HALT;
                                valid_nxt = 1'b0;
                                err_nxt   = 1'b1;
                            end else begin
                                push      = 1'b1;
                                depth_nxt = depth + 3'd1;
                                upc_nxt   = u_target;
                            end
                        end
                        F_RET: begin
                            if (depth == 3'd0) begin
                                state_nxt = S_HALT;
                                valid_nxt = 1'b0;
                                err_nxt   = 1'b1;
                            end else begin
                                depth_nxt = depth - 3'd1;
                                upc_nxt   = rstk[top_idx];
                            end
                        end
                        F_END: begin
                            done_nxt  = 1'b1;
                            depth_nxt = 3'd0;
                            // A start arriving with END chains straight into the next routine.
                            if (u_start) begin
                                upc_nxt = u_entry_addr;
                            end else begin
                                state_nxt = S_IDLE;
                                valid_nxt = 1'b0;
                            end
                        end
                        default: begin
                            state_nxt = S_HALT;
                            valid_nxt = 1'b0;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            upc     <= '0;
            u_valid <= 1'b0;
            u_done  <= 1'b0;
            u_err   <= 1'b0;
            depth   <= 3'd0;
        end else begin
            state   <= state_nxt;
            upc     <= upc_nxt;
            u_valid <= valid_nxt;
            u_done  <= done_nxt;
            u_err   <= err_nxt;
            depth   <= depth_nxt;
        end
    end

    // Stack contents need no reset: occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push) rstk[push_idx] <= upc_inc;
    end

    assign u_addr     = upc;
    assign u_busy     = (state == S_RUN);
    assign u_rs_depth = depth;

endmodule

// File: tb/tb_ucode_useq.sv
// Directed bench for ucode_useq: linear stimulus with hand-computed expectations.
module tb_ucode_useq;

    logic       clk = 1'b0;
    logic       reset;
    logic       u_start;
    logic [8:0] u_entry_addr;
    logic       u_flush;
    logic       u_stall;
    logic [2:0] u_nxt_fmt;
    logic [8:0] u_target;
    logic [1:0] br_sel;
    logic [8:0] u_addr;
    logic       u_valid, u_busy, u_done, u_err;
    logic [2:0] u_rs_depth;

    int checks   = 0;
    int failures = 0;

    ucode_useq #(.RSTK_DEPTH(2), .AW(9)) dut (
        .clk(clk), .reset(reset), .u_start(u_start), .u_entry_addr(u_entry_addr),
        .u_flush(u_flush), .u_stall(u_stall), .u_nxt_fmt(u_nxt_fmt),
        .u_target(u_target), .br_sel(br_sel), .u_addr(u_addr), .u_valid(u_valid),
        .u_busy(u_busy), .u_done(u_done), .u_err(u_err), .u_rs_depth(u_rs_depth)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; u_start = 0; u_entry_addr = 0; u_flush = 0; u_stall = 0;
        u_nxt_fmt = 3'b000; u_target = 0; br_sel = 0;
        tick(); tick();
        chk("rst_addr", u_addr, 9'h000);
        chk("rst_valid", u_valid, 0);
        chk("rst_busy", u_busy, 0);
        chk("rst_done", u_done, 0);
        chk("rst_err", u_err, 0);
        chk("rst_depth", u_rs_depth, 0);
        reset = 1'b0;

        // Reset asserted mid-routine at upc 0x055, depth 1
        u_start = 1; u_entry_addr = 9'h050; tick();
        chk("mid_start_addr", u_addr, 9'h050);
        u_start = 0; u_nxt_fmt = 3'b011; u_target = 9'h055; tick();
        chk("mid_call_addr", u_addr, 9'h055);
        chk("mid_call_depth", u_rs_depth, 1);
        u_nxt_fmt = 3'b000;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", u_addr, 9'h000);
        chk("async_rst_valid", u_valid, 0);
        chk("async_rst_depth", u_rs_depth, 0);
        chk("async_rst_err", u_err, 0);
        @(negedge clk); reset = 1'b0;

        // Dispatch and sequential wrap
        u_start = 1; u_entry_addr = 9'h1FE; tick();
        chk("seq_addr0", u_addr, 9'h1FE);
        chk("seq_valid0", u_valid, 1);
        chk("seq_busy0", u_busy, 1);
        u_start = 0; u_nxt_fmt = 3'b000; tick();
        chk("seq_addr1", u_addr, 9'h1FF);
        tick();
        chk("seq_wrap", u_addr, 9'h000);
        chk("seq_valid2", u_valid, 1);

        // Branch selects
        u_nxt_fmt = 3'b010; u_target = 9'h040;
        br_sel = 2'b00; tick(); chk("br00", u_addr, 9'h001);
        br_sel = 2'b01; tick(); chk("br01", u_addr, 9'h002);
        br_sel = 2'b10; tick(); chk("br10", u_addr, 9'h040);
        br_sel = 2'b11; tick(); chk("br11", u_addr, 9'h041);

        // Stall holds upc
        u_stall = 1; u_nxt_fmt = 3'b001; u_target = 9'h123;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", u_addr, 9'h041);
            chk("stall_valid", u_valid, 1);
        end
        u_stall = 0;

        // END without start
        u_nxt_fmt = 3'b101; tick();
        chk("end_done", u_done, 1);
        chk("end_busy", u_busy, 0);
        chk("end_valid", u_valid, 0);
        tick();
        chk("end_done_drop", u_done, 0);

        // Nested calls overflow the two-entry stack
        u_start = 1; u_entry_addr = 9'h010; tick();
        chk("call_entry", u_addr, 9'h010);
        u_start = 0; u_nxt_fmt = 3'b011; u_target = 9'h100; tick();
        chk("call1_addr", u_addr, 9'h100);
        chk("call1_depth", u_rs_depth, 1);
        u_target = 9'h180; tick();
        chk("call2_addr", u_addr, 9'h180);
        chk("call2_depth", u_rs_depth, 2);
        u_target = 9'h1C0; tick();
        chk("ovf_err", u_err, 1);
        chk("ovf_valid", u_valid, 0);
        chk("ovf_busy", u_busy, 0);
        chk("ovf_addr", u_addr, 9'h180);
        chk("ovf_depth", u_rs_depth, 2);
        u_flush = 1; tick(); u_flush = 0;
        chk("flush_busy", u_busy, 0);
        chk("flush_err_sticky", u_err, 1);
        chk("flush_depth", u_rs_depth, 0);

        // CALL / RET pair
        u_start = 1; u_entry_addr = 9'h010; tick();
        u_start = 0; u_nxt_fmt = 3'b011; u_target = 9'h100; tick();
        chk("cr_call", u_addr, 9'h100);
        u_nxt_fmt = 3'b100; tick();
        chk("cr_ret_addr", u_addr, 9'h011);
        chk("cr_ret_depth", u_rs_depth, 0);
        chk("cr_ret_valid", u_valid, 1);

        // END with back-to-back start
        u_nxt_fmt = 3'b101; u_start = 1; u_entry_addr = 9'h020; tick();
        chk("b2b_done", u_done, 1);
        chk("b2b_addr", u_addr, 9'h020);
        chk("b2b_busy", u_busy, 1);
        chk("b2b_valid", u_valid, 1);
        u_start = 0; u_nxt_fmt = 3'b000; tick();
        chk("b2b_done_drop", u_done, 0);
        chk("b2b_cont", u_addr, 9'h021);

        // END while stalled
        u_nxt_fmt = 3'b101; u_stall = 1; tick();
        chk("stall_end_nodone", u_done, 0);
        chk("stall_end_busy", u_busy, 1);
        tick();
        chk("stall_end_nodone2", u_done, 0);
        u_stall = 0; tick();
        chk("stall_end_done", u_done, 1);
        chk("stall_end_idle", u_busy, 0);
        tick();
        chk("stall_end_drop", u_done, 0);

        // RET on empty stack
        do_reset();
        chk("err_clear", u_err, 0);
        u_start = 1; u_entry_addr = 9'h030; tick();
        u_start = 0; u_nxt_fmt = 3'b100; tick();
        chk("ret_empty_err", u_err, 1);
        chk("ret_empty_valid", u_valid, 0);
        chk("ret_empty_addr", u_addr, 9'h030);

        // Reserved format
        do_reset();
        u_start = 1; u_entry_addr = 9'h030; tick();
        u_start = 0; u_nxt_fmt = 3'b110; tick();
        chk("rsv_err", u_err, 1);
        chk("rsv_valid", u_valid, 0);
        chk("rsv_busy", u_busy, 0);

        // Flush with simultaneous start
        u_flush = 1; u_start = 1; u_entry_addr = 9'h077; tick();
        chk("fs_busy", u_busy, 0);
        chk("fs_valid", u_valid, 0);
        chk("fs_addr", u_addr, 9'h030);
        u_flush = 0; u_start = 0; tick();
        chk("fs_still_idle", u_busy, 0);
        chk("fs_err", u_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ucode_useq.md
Name: ucode_useq

Overview:
- Microcode sequencer that owns the 9-bit micro-PC (upc) driving the ucode ROM address.
- Consumes the branch select pair {bit1,bit0} from the branch-bit decoder and the next-address format field of the current microword, and produces the next upc.
- Keeps a small return stack for micro-subroutines.
- Sits directly downstream of the ucode decode/branch-select logic and upstream of the ROM.

Parameters:
RSTK_DEPTH, 2, return-stack entries (1..4)
AW, 9, micro-address width

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
u_start  in  1  dispatch request to begin a microroutine
u_entry_addr  in  AW  entry address accompanying u_start
u_flush  in  1  trap/abort: terminate routine immediately
u_stall  in  1  pipeline hold
u_nxt_fmt  in  3  next-address format of current microword
u_target  in  AW  jump/branch target field of current microword
br_sel  in  2  {bit1,bit0} from branch-bit decoder
u_addr  out  AW  registered upc to ROM
u_valid  out  1  u_addr holds a live microword
u_busy  out  1  routine in progress (state RUN)
u_done  out  1  one-cycle pulse: routine retired
u_err  out  1  sticky sequencing error
u_rs_depth  out  3  current return-stack occupancy

Behaviour:
- Reset (async, any state) sets:
  - state=IDLE, upc=0, u_valid=0, u_busy=0, u_done=0, u_err=0
  - stack empty, u_rs_depth=0
- States: IDLE, RUN, HALT.
- Priority each cycle: reset > u_flush > u_stall > normal.
- u_flush, from any state:
  - next state IDLE, stack cleared, u_valid=0, no u_done.
  - u_start in the same cycle is ignored.
  - u_err is not cleared; only reset clears it.
- u_stall, with no flush: all state, upc and stack hold. u_done goes 0, so a pulse is never stretched.
- IDLE:
  - u_start=1 -> upc=u_entry_addr, state RUN, u_valid=1 the next cycle (1-cycle latency).
  - Otherwise upc holds.
- RUN, not stalled, decode u_nxt_fmt:
  - 000 CONT: upc=upc+1.
  - 001 JUMP: upc=u_target.
  - 010 BR, selected by br_sel:
    - 00 or 01 -> upc+1
    - 10 -> u_target
    - 11 -> u_target+1
  - 011 CALL: push upc+1; upc=u_target. If stack full -> HALT, u_err=1.
  - 100 RET: upc=pop. If stack empty -> HALT, u_err=1.
  - 101 END: state IDLE, u_valid=0, u_done=1 for exactly the next cycle, stack cleared.
    - If u_start=1 in the same cycle: upc=u_entry_addr, state stays RUN, u_valid stays 1, u_done still pulses (back-to-back dispatch).
  - 110, 111 reserved: HALT, u_err=1.
- u_start while RUN is ignored. Dispatch must watch u_busy.
- HALT:
  - u_valid=0, upc frozen, u_busy=0.
  - Exit only by u_flush (to IDLE) or reset.
- Arithmetic:
  - upc+1 and u_target+1 are AW-bit modular (0x1FF+1 -> 0x000), no flag.
  - Stack entries are AW bits.
- Stack:
  - LIFO; u_rs_depth = occupancy.
  - A failed CALL or RET leaves stack contents unchanged.
- u_busy = (state==RUN). u_valid equals u_busy except that it drops with END and HALT.
- u_nxt_fmt, u_target and br_sel are sampled only in RUN while not stalled. They are don't-care otherwise.

Test Plan:
- Reset mid-RUN at upc=0x055 with depth 1 -> same cycle: u_addr=0, u_valid=0, u_rs_depth=0, u_err=0.
- Dispatch and sequential run:
  - u_start with entry 0x1FE, then CONT twice -> u_addr 0x1FE, 0x1FF, 0x000 (wrap), u_valid=1 throughout.
- BR coverage with u_target=0x040, one case per br_sel value:
  - br_sel=00 -> upc+1
  - br_sel=01 -> upc+1
  - br_sel=10 -> 0x040
  - br_sel=11 -> 0x041
  - u_stall=1 for 3 cycles mid-routine -> u_addr holds.
- Call/return:
  - CALL at 0x010 to 0x100, then CALL at 0x100 to 0x180 -> depth 2.
  - Third CALL -> HALT, u_err=1, u_valid=0.
  - u_flush -> IDLE, u_err stays 1.
  - Separate run: CALL/RET pair returns to 0x011.
- END with u_start=1 and entry 0x020 -> next cycle u_done=1, u_addr=0x020, u_busy=1.
  - END without start -> u_done single pulse, u_busy=0.
  - END while stalled -> no pulse until the stall releases.
- Error cases:
  - RET at depth 0 -> u_err=1.
  - Reserved fmt 110 -> u_err=1.
  - u_flush and u_start in the same cycle -> IDLE, start ignored, u_addr unchanged.
